casez_match_table: RTL and testbench

- Programmable wildcard match table; hardware form of a parametrised casez with priority, default arm and overlap detection.
- Holds ENTRIES {key, care-mask, result} rows and looks up a streamed key against them.
- The lowest-index matching row wins. A miss returns DEFAULT_RES.
- Two-stage valid/ready pipeline. Flags overlapping matches (unique-case violation) and supports a sequenced table clear.
- Sits in front of decode/dispatch logic that previously used fixed casez statements.

---
 rtl/casez_match_pkg.sv | 9 +
 rtl/casez_match_prio.sv | 24 ++
 rtl/casez_match_table.sv | 159 +++++++++++++++
 tb/tb_casez_match_table.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/casez_match_pkg.sv
// Shared types for the programmable wildcard match table.
package casez_match_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_e;

endpackage

// File: rtl/casez_match_prio.sv
// Priority resolver: lowest set bit of the match vector, plus any/multiple flags.
module casez_match_prio #(
  parameter  int ENTRIES = 8,
  localparam int IDX_W   = $clog2(ENTRIES)
) (
  input  logic [ENTRIES-1:0] match,
  output logic [IDX_W-1:0]   idx,
  output logic               hit,
  output logic               multi
);

  always_comb begin
    idx = '0;
    // Walk downwards so the lowest matching index is the last assignment.
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (match[i]) idx = IDX_W'(i);
    end
  end

  assign hit   = |match;
  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multi = |(match & (match - ENTRIES'(1)));

endmodule

// File: rtl/casez_match_table.sv
// Wildcard match table with lowest-index priority, overlap flag and sequenced clear.
// state | meaning
// IDLE  | table usable; clr_req starts a clear
// CLEAR | invalidating row cnt each cycle; writes and new lookups blocked
module casez_match_table
  import casez_match_pkg::*;
#(
  parameter  int               KEY_W       = 20,
  parameter  int               RES_W       = 8,
  parameter  int               ENTRIES     = 8,
  parameter  logic [RES_W-1:0] DEFAULT_RES = '0,
  localparam int               IDX_W       = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  output logic             wr_ready,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [KEY_W-1:0] wr_key,
  input  logic [KEY_W-1:0] wr_care,
  input  logic [RES_W-1:0] wr_res,
  input  logic             wr_vld,
  input  logic             clr_req,
  output logic             clr_busy,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [KEY_W-1:0] in_key,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_hit,
  output logic [IDX_W-1:0] out_idx,
  output logic [RES_W-1:0] out_res,
  output logic             out_multi
);

  typedef struct packed {
    logic             hit;
    logic [IDX_W-1:0] idx;
    logic [RES_W-1:0] res;
    logic             multi;
  } match_res_t;

  logic [KEY_W-1:0]   key_q  [ENTRIES];
  logic [KEY_W-1:0]   care_q [ENTRIES];
  logic [RES_W-1:0]   res_q  [ENTRIES];
  logic [ENTRIES-1:0] vld_q;

  clr_state_e       state;
  logic [IDX_W-1:0] cnt;

  logic [ENTRIES-1:0] match;
  logic [IDX_W-1:0]   prio_idx;
  logic               prio_hit;
  logic               prio_multi;
  match_res_t         lookup_d;
  match_res_t         s1_q;
  match_res_t         s2_q;
  logic               s1_valid;
  logic               s2_valid;
  logic               s1_ld;
  logic               s2_ld;
  logic               accept;
  logic               wr_fire;

  assign wr_ready = !clr_busy;
  assign wr_fire  = wr_en && wr_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      clr_busy <= 1'b0;
      vld_q    <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        key_q[i]  <= '0;
        care_q[i] <= '0;
        res_q[i]  <= '0;
      end
    end else begin
      if (wr_fire) begin
        key_q[wr_idx]  <= wr_key;
        care_q[wr_idx] <= wr_care;
        res_q[wr_idx]  <= wr_res;
        vld_q[wr_idx]  <= wr_vld;
      end
      case (state)
        IDLE: begin
          if (clr_req) begin
            state    <= CLEAR;
            cnt      <= '0;
            clr_busy <= 1'b1;
          end
        end
        CLEAR: begin
          vld_q[cnt] <= 1'b0;
          if (cnt == IDX_W'(ENTRIES - 1)) begin
            state    <= IDLE;
            cnt      <= '0;
            clr_busy <= 1'b0;
          end else begin
            cnt <= cnt + IDX_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      match[i] = vld_q[i] && (((in_key ^ key_q[i]) & care_q[i]) == '0);
    end
  end

  casez_match_prio #(.ENTRIES(ENTRIES)) u_prio (
    .match (match),
    .idx   (prio_idx),
    .hit   (prio_hit),
    .multi (prio_multi)
  );

  always_comb begin
    lookup_d.hit   = prio_hit;
    lookup_d.idx   = prio_idx;
    lookup_d.res   = prio_hit ? res_q[prio_idx] : DEFAULT_RES;
    lookup_d.multi = prio_multi;
  end

  // A stage may load when empty or when its content leaves in the same cycle.
  assign s2_ld    = !s2_valid || out_ready;
  assign s1_ld    = !s1_valid || s2_ld;
  assign in_ready = !clr_busy && s1_ld;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s1_q     <= '0;
      s2_q     <= '0;
    end else begin
      if (s1_ld) begin
        s1_valid <= accept;
        if (accept) s1_q <= lookup_d;
      end
      if (s2_ld) begin
        s2_valid <= s1_valid;
        if (s1_valid) s2_q <= s1_q;
      end
    end
  end

  assign out_valid = s2_valid;
  assign out_hit   = s2_q.hit;
  assign out_idx   = s2_q.idx;
  assign out_res   = s2_q.res;
  assign out_multi = s2_q.multi;

endmodule

// File: tb/tb_casez_match_table.sv
// Randomized and directed checks of casez_match_table against a row-scan reference model.
module tb_casez_match_table;

  localparam int             KEY_W   = 20;
  localparam int             RES_W   = 8;
  localparam int             ENTRIES = 8;
  localparam int             IDX_W   = 3;
  localparam logic [RES_W-1:0] DEF   = 8'h00;

  logic             clk;
  logic             rst_n;
  logic             wr_en;
  logic             wr_ready;
  logic [IDX_W-1:0] wr_idx;
  logic [KEY_W-1:0] wr_key;
  logic [KEY_W-1:0] wr_care;
  logic [RES_W-1:0] wr_res;
  logic             wr_vld;
  logic             clr_req;
  logic             clr_busy;
  logic             in_valid;
  logic             in_ready;
  logic [KEY_W-1:0] in_key;
  logic             out_valid;
  logic             out_ready;
  logic             out_hit;
  logic [IDX_W-1:0] out_idx;
  logic [RES_W-1:0] out_res;
  logic             out_multi;

  casez_match_table #(
    .KEY_W(KEY_W), .RES_W(RES_W), .ENTRIES(ENTRIES), .DEFAULT_RES(DEF)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_ready(wr_ready), .wr_idx(wr_idx), .wr_key(wr_key),
    .wr_care(wr_care), .wr_res(wr_res), .wr_vld(wr_vld),
    .clr_req(clr_req), .clr_busy(clr_busy),
    .in_valid(in_valid), .in_ready(in_ready), .in_key(in_key),
    .out_valid(out_valid), .out_ready(out_ready), .out_hit(out_hit),
    .out_idx(out_idx), .out_res(out_res), .out_multi(out_multi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic             hit;
    logic [IDX_W-1:0] idx;
    logic [RES_W-1:0] res;
    logic             multi;
  } exp_t;

  logic [KEY_W-1:0] m_key  [ENTRIES];
  logic [KEY_W-1:0] m_care [ENTRIES];
  logic [RES_W-1:0] m_res  [ENTRIES];
  logic             m_vld  [ENTRIES];
  exp_t             sb[$];

  function automatic exp_t ref_lookup(input logic [KEY_W-1:0] k);
    exp_t e;
    int   n;
    n       = 0;
    e.hit   = 1'b0;
    e.idx   = '0;
    e.res   = DEF;
    for (int i = 0; i < ENTRIES; i++) begin
      if (m_vld[i] && ((k ^ m_key[i]) & m_care[i]) == '0) begin
        n++;
        if (!e.hit) begin
          e.hit = 1'b1;
          e.idx = IDX_W'(i);
          e.res = m_res[i];
        end
      end
    end
    e.multi = (n >= 2);
    return e;
  endfunction

  exp_t             cur_out;
  exp_t             prev_out;
  exp_t             e_pop;
  logic             hold_prev = 1'b0;
  logic             last_hit;
  logic [IDX_W-1:0] last_idx;
  logic [RES_W-1:0] last_res;
  logic             last_multi;
  int               n_out = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      hold_prev = 1'b0;
      for (int i = 0; i < ENTRIES; i++) begin
        m_vld[i] = 1'b0; m_key[i] = '0; m_care[i] = '0; m_res[i] = '0;
      end
    end else begin
      cur_out = {out_hit, out_idx, out_res, out_multi};
      if (hold_prev) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_data", 32'(cur_out), 32'(prev_out));
      end
      hold_prev = out_valid && !out_ready;
      prev_out  = cur_out;
      if (in_valid && in_ready) sb.push_back(ref_lookup(in_key));
      if (out_valid && out_ready) begin
        chk("out_expected", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e_pop = sb.pop_front();
          chk("out_hit", 32'(out_hit), 32'(e_pop.hit));
          chk("out_idx", 32'(out_idx), 32'(e_pop.idx));
          chk("out_res", 32'(out_res), 32'(e_pop.res));
          chk("out_multi", 32'(out_multi), 32'(e_pop.multi));
        end
        last_hit = out_hit; last_idx = out_idx; last_res = out_res; last_multi = out_multi;
        n_out++;
      end
      if (wr_en && wr_ready) begin
        m_key[wr_idx] = wr_key; m_care[wr_idx] = wr_care;
        m_res[wr_idx] = wr_res; m_vld[wr_idx] = wr_vld;
      end
      if (clr_req && !clr_busy) begin
        for (int i = 0; i < ENTRIES; i++) m_vld[i] = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_row(input int idx, input logic [KEY_W-1:0] k, input logic [KEY_W-1:0] c,
                        input logic [RES_W-1:0] r);
    wr_en = 1'b1; wr_idx = IDX_W'(idx); wr_key = k; wr_care = c; wr_res = r; wr_vld = 1'b1;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic lookup(input logic [KEY_W-1:0] k);
    int   n;
    logic acc;
    n = 0;
    in_valid = 1'b1;
    in_key   = k;
    do begin
      @(negedge clk);
      acc = in_ready;
      tick();
      n++;
    end while (!acc && n < 60);
    in_valid = 1'b0;
    chk("lookup_accepted", 32'(acc), 32'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    while (sb.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    chk("drain_done", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_n;
    int bad_rdy;
    int n0;
    rst_n = 1'b0; wr_en = 1'b0; wr_idx = '0; wr_key = '0; wr_care = '0; wr_res = '0;
    wr_vld = 1'b0; clr_req = 1'b0; in_valid = 1'b0; in_key = '0; out_ready = 1'b1;
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'({out_hit, out_idx, out_res, out_multi}), 32'd0);
    chk("rst_clr_busy", 32'(clr_busy), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rel_in_ready", 32'(in_ready), 32'd1);
    chk("rel_wr_ready", 32'(wr_ready), 32'd1);
    tick();

    // Empty table, latency: result visible two cycles after the acceptance cycle.
    in_valid = 1'b1; in_key = 20'h00000;
    @(negedge clk);
    chk("lat_accept", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("lat_not_yet", 32'(out_valid), 32'd0);
    tick();
    @(negedge clk);
    chk("lat_valid", 32'(out_valid), 32'd1);
    chk("empty_hit", 32'(out_hit), 32'd0);
    chk("empty_res", 32'(out_res), 32'(DEF));
    chk("empty_idx", 32'(out_idx), 32'd0);
    chk("empty_multi", 32'(out_multi), 32'd0);
    tick();

    wr_row(0, 20'h80000, 20'h80000, 8'h11);
    wr_row(1, 20'h00400, 20'h07F00, 8'h22);
    wr_row(2, 20'h00000, 20'h00000, 8'h33);
    lookup(20'h00400); drain();
    chk("k00400_hit", 32'(last_hit), 32'd1);
    chk("k00400_idx", 32'(last_idx), 32'd1);
    chk("k00400_res", 32'(last_res), 32'h22);
    lookup(20'h80400); drain();
    chk("k80400_idx", 32'(last_idx), 32'd0);
    chk("k80400_res", 32'(last_res), 32'h11);
    chk("k80400_multi", 32'(last_multi), 32'd1);
    lookup(20'h00600); drain();
    chk("k00600_idx", 32'(last_idx), 32'd2);
    chk("k00600_res", 32'(last_res), 32'h33);
    chk("k00600_multi", 32'(last_multi), 32'd0);

    // Backpressure: out_ready low for 5 cycles while 4 keys are offered.
    n0 = n_out;
    out_ready = 1'b0;
    fork
      begin
        lookup(20'h00400); lookup(20'h80000); lookup(20'h00600); lookup(20'h12345);
      end
      begin
        repeat (3) @(negedge clk);
        chk("bp_in_ready_low", 32'(in_ready), 32'd0);
        repeat (2) @(negedge clk);
        tick();
        out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_count", 32'(n_out - n0), 32'd4);

    // Write and lookup of the same row in the same cycle.
    wr_en = 1'b1; wr_idx = 3'd1; wr_key = 20'h00400; wr_care = 20'h07F00;
    wr_res = 8'h44; wr_vld = 1'b1;
    in_valid = 1'b1; in_key = 20'h00400;
    @(negedge clk);
    chk("col_both_ready", 32'({in_ready, wr_ready}), 32'd3);
    tick();
    wr_en = 1'b0; in_valid = 1'b0;
    drain();
    chk("col_old_row", 32'(last_res), 32'h22);
    lookup(20'h00400); drain();
    chk("col_new_row", 32'(last_res), 32'h44);

    // Randomized traffic, writes and occasional clears.
    for (int c = 0; c < 400; c++) begin
      wr_en    = ($urandom % 5 == 0);
      wr_idx   = IDX_W'($urandom % ENTRIES);
      wr_key   = KEY_W'($urandom & 32'h000F3);
      wr_care  = KEY_W'($urandom & 32'h000F3);
      wr_res   = RES_W'($urandom);
      wr_vld   = ($urandom % 4 != 0);
      clr_req  = ($urandom % 80 == 0);
      in_valid = ($urandom % 3 != 0);
      in_key   = KEY_W'($urandom & 32'h000F3);
      out_ready = ($urandom % 4 != 0);
      tick();
    end
    wr_en = 1'b0; clr_req = 1'b0; in_valid = 1'b0;
    drain();
    repeat (10) tick();

    // Sequenced clear.
    wr_row(1, 20'h00400, 20'h07F00, 8'h22);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    busy_n = 0; bad_rdy = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (!clr_busy) break;
      busy_n++;
      if (in_ready || wr_ready) bad_rdy++;
    end
    chk("clr_busy_cycles", 32'(busy_n), 32'd8);
    chk("clr_ready_low", 32'(bad_rdy), 32'd0);
    tick();
    lookup(20'h00400); drain();
    chk("after_clr_miss", 32'(last_hit), 32'd0);

    // Asynchronous reset in the middle of a clear with a result held at the output.
    wr_row(0, 20'h80000, 20'h80000, 8'h11);
    out_ready = 1'b0;
    lookup(20'h80000);
    tick(); tick();
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_data", 32'({out_hit, out_idx, out_res, out_multi}), 32'd0);
    chk("mid_rst_busy", 32'(clr_busy), 32'd0);
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'({in_ready, wr_ready, clr_busy}), 32'b110);
    tick();
    lookup(20'h80000); drain();
    chk("post_rst_miss", 32'(last_hit), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
